game_judge: RTL and testbench
=============================

Name: game_judge

Overview:
- Rule-evaluation stage directly upstream of the game state FSM; drives its start, restart, over and success inputs, which are currently tied off.
- Each frame tick it compares Mario's box against the barrel and Queue boxes.
- Maintains a lives counter with post-hit invulnerability.
- Turns the player's start key into start/restart requests.

Parameters:
- MARIO_W, 34, Mario sprite width (px)
- MARIO_H, 36, Mario sprite height (px)
- QUEUE_W, 44, Queue sprite width (px)
- QUEUE_H, 50, Queue sprite height (px)
- LIVES, 3, lives loaded at game start (1..7)
- HIT_FRAMES, 2, consecutive overlapping ticks needed to register a hit (1..15)
- INVULN_FRAMES, 60, ticks during which hits are ignored after a non-fatal hit (0..255)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- tick  in  1  one-clk frame-tick enable (rising edge of the slow game clock, generated externally)
- game_state  in  2  current state: 00 INITIAL, 01 RUNNING, 10 OVER, 11 SUCCESS
- key_start  in  1  start/restart key level, already synchronised to clk
- mario_x  in  10  Mario top-left x
- mario_y  in  9  Mario top-left y
- barrel_x  in  10  barrel top-left x
- barrel_y  in  9  barrel top-left y
- barrel_w  in  10  current barrel width
- barrel_h  in  9  current barrel height
- queue_x  in  10  Queue centre x
- queue_y  in  9  Queue centre y
- start  out  1  one-clk pulse: begin game
- restart  out  1  one-clk pulse: return to INITIAL
- over  out  1  sticky level: game lost
- success  out  1  sticky level: Queue reached
- lives  out  3  remaining lives
- invuln  out  1  high while invulnerability window is active

Behaviour:
- Single clock domain. All state resets synchronously when rst=1:
  - start=0, restart=0, over=0, success=0, invuln=0, lives=LIVES
  - hit counter=0, invuln counter=0, key edge register=0
- Key edge detection: key_rise = key_start & ~key_q, where key_q is key_start registered every clk.
  - game_state==INITIAL and key_rise: start=1 for exactly one clk.
  - game_state is OVER or SUCCESS and key_rise: restart=1 for exactly one clk.
  - key_rise has no effect in RUNNING.
- When game_state==INITIAL (any cycle):
  - lives reloads to LIVES.
  - over, success, invuln and both counters clear.
- Overlap tests use 11-bit unsigned arithmetic so sums never wrap. Overlap is strict: touching edges is not an overlap.
  - Barrel hit_now: mario_x < barrel_x+barrel_w, barrel_x < mario_x+MARIO_W, mario_y < barrel_y+barrel_h, barrel_y < mario_y+MARIO_H.
  - Queue box: top-left = (queue_x-QUEUE_W/2, queue_y-QUEUE_H/2), computed signed 12-bit; a negative result clamps to 0.
  - goal_now uses the same strict test against the Queue box.
- Evaluation happens only on clk cycles with tick=1, game_state==RUNNING, over=0 and success=0. On all other cycles counters hold, except the clears listed above.
- Per evaluated tick, in priority order:
  1. goal_now: success=1 (registered, visible the clk after the tick). Any simultaneous hit is ignored.
  2. invuln=1: invuln counter decrements. When it reaches 0, invuln=0. hit counter forced to 0.
  3. hit_now: hit counter increments. When the new value equals HIT_FRAMES:
     - hit counter clears and lives decrements.
     - If the new lives value is 0: over=1.
     - Otherwise: invuln=1 and invuln counter=INVULN_FRAMES. If INVULN_FRAMES=0, invuln stays 0.
  4. Otherwise (no overlap): hit counter clears, so hits must be consecutive.
- lives never underflows; it saturates at 0.
- over and success hold until game_state==INITIAL or rst. They are mutually exclusive: whichever is set first blocks the other.
- Latency: over, success and lives update one clk after the deciding tick. start and restart assert one clk after the key_start rising edge is sampled.
- rst in the middle of a game returns everything to reset values on the next edge. No pulse is emitted on that edge.

Test Plan:
- Reset, game_state=INITIAL, raise key_start -> exactly one start pulse, lives=3. Holding the key produces no further pulse; release and re-press gives a second pulse.
- RUNNING, Mario (100,200) and barrel (120,210, 32x24) overlapping for 2 ticks -> lives 3->2, invuln=1. Overlap continues for 60 more ticks -> lives stays 2; invuln=0 after the 60th tick.
- Barrel at barrel_x=134 (exactly touching Mario's right edge at 100+34) -> no hit, hit counter stays 0. Alternating overlap/no-overlap ticks with HIT_FRAMES=2 -> no life lost.
- Three separate registered hits, with invulnerability windows expired between them -> lives reaches 0, over=1 one clk after the third hit tick. Further ticks change nothing. key_start rise -> one restart pulse.
- Mario overlapping the Queue box (queue centre (300,60), Mario (290,50)) on the same tick as a barrel hit -> success=1, lives unchanged, over stays 0.
- Set game_state=INITIAL after an OVER -> over=0, lives=3, invuln=0. Asserting rst mid-invulnerability -> invuln=0, lives=3 on the next clk.

Source files
------------

// File: rtl/game_judge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | game_judge: per-tick collision/goal rules, lives and start/restart.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module game_judge #(
  parameter int MARIO_W       = 34,
  parameter int MARIO_H       = 36,
  parameter int QUEUE_W       = 44,
  parameter int QUEUE_H       = 50,
  parameter int LIVES         = 3,
  parameter int HIT_FRAMES    = 2,
  parameter int INVULN_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [1:0] game_state,
  input  logic       key_start,
  input  logic [9:0] mario_x,
  input  logic [8:0] mario_y,
  input  logic [9:0] barrel_x,
  input  logic [8:0] barrel_y,
  input  logic [9:0] barrel_w,
  input  logic [8:0] barrel_h,
  input  logic [9:0] queue_x,
  input  logic [8:0] queue_y,
  output logic       start,
  output logic       restart,
  output logic       over,
  output logic       success,
  output logic [2:0] lives,
  output logic       invuln
);

  localparam logic [1:0] ST_INITIAL = 2'b00;
  localparam logic [1:0] ST_RUNNING = 2'b01;
  localparam logic [1:0] ST_OVER    = 2'b10;
  localparam logic [1:0] ST_SUCCESS = 2'b11;

  logic       key_q, key_d;
  logic       start_q, start_d;
  logic       restart_q, restart_d;
  logic       over_q, over_d;
  logic       success_q, success_d;
  logic       invuln_q, invuln_d;
  logic [2:0] lives_q, lives_d;
  logic [3:0] hit_cnt_q, hit_cnt_d;
  logic [7:0] inv_cnt_q, inv_cnt_d;

  logic [10:0] m_x, m_y, b_x, b_y, q_x, q_y;
  logic [11:0] q_x_s, q_y_s;
  logic        hit_now, goal_now, key_rise, eval;
  logic [3:0]  hit_inc;
  logic [2:0]  lives_dec;

  assign m_x = {1'b0, mario_x};
  assign m_y = {2'b00, mario_y};
  assign b_x = {1'b0, barrel_x};
  assign b_y = {2'b00, barrel_y};

  // Queue is given by its centre; the box corner may fall off-screen and clamps to 0.
  assign q_x_s = {2'b00, queue_x} - 12'(QUEUE_W / 2);
  assign q_y_s = {3'b000, queue_y} - 12'(QUEUE_H / 2);
  assign q_x   = q_x_s[11] ? 11'd0 : q_x_s[10:0];
  assign q_y   = q_y_s[11] ? 11'd0 : q_y_s[10:0];

  assign hit_now  = (m_x < b_x + {1'b0, barrel_w}) && (b_x < m_x + 11'(MARIO_W)) &&
                    (m_y < b_y + {2'b00, barrel_h}) && (b_y < m_y + 11'(MARIO_H));
  assign goal_now = (m_x < q_x + 11'(QUEUE_W)) && (q_x < m_x + 11'(MARIO_W)) &&
                    (m_y < q_y + 11'(QUEUE_H)) && (q_y < m_y + 11'(MARIO_H));

  assign key_rise  = key_start & ~key_q;
  assign eval      = tick && (game_state == ST_RUNNING) && !over_q && !success_q;
  assign hit_inc   = hit_cnt_q + 4'd1;
  assign lives_dec = (lives_q == 3'd0) ? 3'd0 : lives_q - 3'd1;

  always_comb begin
    key_d     = key_start;
    start_d   = (game_state == ST_INITIAL) && key_rise;
    restart_d = ((game_state == ST_OVER) || (game_state == ST_SUCCESS)) && key_rise;
    over_d    = over_q;
    success_d = success_q;
    invuln_d  = invuln_q;
    lives_d   = lives_q;
    hit_cnt_d = hit_cnt_q;
    inv_cnt_d = inv_cnt_q;

    if (game_state == ST_INITIAL) begin
      lives_d   = 3'(LIVES);
      over_d    = 1'b0;
      success_d = 1'b0;
      invuln_d  = 1'b0;
      hit_cnt_d = 4'd0;
      inv_cnt_d = 8'd0;
    end else if (eval) begin
      if (goal_now) begin
        success_d = 1'b1;
      end else if (invuln_q) begin
        inv_cnt_d = inv_cnt_q - 8'd1;
        hit_cnt_d = 4'd0;
        if (inv_cnt_q == 8'd1) invuln_d = 1'b0;
      end else if (hit_now) begin
        hit_cnt_d = hit_inc;
        if (hit_inc == 4'(HIT_FRAMES)) begin
          hit_cnt_d = 4'd0;
          lives_d   = lives_dec;
          if (lives_dec == 3'd0) begin
            over_d = 1'b1;
          end else if (INVULN_FRAMES != 0) begin
            invuln_d  = 1'b1;
            inv_cnt_d = 8'(INVULN_FRAMES);
          end
        end
      end else begin
        hit_cnt_d = 4'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_q     <= 1'b0;
      start_q   <= 1'b0;
      restart_q <= 1'b0;
      over_q    <= 1'b0;
      success_q <= 1'b0;
      invuln_q  <= 1'b0;
      lives_q   <= 3'(LIVES);
      hit_cnt_q <= 4'd0;
      inv_cnt_q <= 8'd0;
    end else begin
      key_q     <= key_d;
      start_q   <= start_d;
      restart_q <= restart_d;
      over_q    <= over_d;
      success_q <= success_d;
      invuln_q  <= invuln_d;
      lives_q   <= lives_d;
      hit_cnt_q <= hit_cnt_d;
      inv_cnt_q <= inv_cnt_d;
    end
  end

  assign start   = start_q;
  assign restart = restart_q;
  assign over    = over_q;
  assign success = success_q;
  assign lives   = lives_q;
  assign invuln  = invuln_q;

endmodule
`default_nettype wire

// File: tb/tb_game_judge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_game_judge: directed self-checking bench for game_judge.          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_game_judge;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [1:0] game_state;
  logic       key_start;
  logic [9:0] mario_x, barrel_x, barrel_w, queue_x;
  logic [8:0] mario_y, barrel_y, barrel_h, queue_y;
  logic       start, restart, over, success, invuln;
  logic [2:0] lives;

  int checks = 0;
  int errors = 0;

  game_judge dut (
    .clk(clk), .rst(rst), .tick(tick), .game_state(game_state), .key_start(key_start),
    .mario_x(mario_x), .mario_y(mario_y),
    .barrel_x(barrel_x), .barrel_y(barrel_y), .barrel_w(barrel_w), .barrel_h(barrel_h),
    .queue_x(queue_x), .queue_y(queue_y),
    .start(start), .restart(restart), .over(over), .success(success),
    .lives(lives), .invuln(invuln)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick;
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic barrel_on;   // overlaps Mario at (100,200)
    barrel_x = 10'd120; barrel_y = 9'd210;
  endtask

  task automatic barrel_off;
    barrel_x = 10'd600; barrel_y = 9'd400;
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; game_state = 2'b00; key_start = 1'b0;
    mario_x = 10'd100; mario_y = 9'd200;
    barrel_w = 10'd32; barrel_h = 9'd24;
    barrel_off();
    queue_x = 10'd900; queue_y = 9'd400;
    step(); step();
    chk("rst_lives", 32'(lives), 3);
    chk("rst_start", 32'(start), 0);
    chk("rst_over", 32'(over), 0);
    chk("rst_success", 32'(success), 0);
    chk("rst_invuln", 32'(invuln), 0);
    rst = 1'b0;

    // start key in INITIAL
    key_start = 1'b1; step();
    chk("start_pulse", 32'(start), 1);
    chk("start_lives", 32'(lives), 3);
    step(); chk("start_one_clk", 32'(start), 0);
    step(); chk("start_held", 32'(start), 0);
    key_start = 1'b0; step();
    key_start = 1'b1; step();
    chk("start_repress", 32'(start), 1);
    key_start = 1'b0; step();
    chk("start_repress_end", 32'(start), 0);

    // key has no effect while RUNNING
    game_state = 2'b01;
    key_start = 1'b1; step();
    chk("run_key_start", 32'(start), 0);
    chk("run_key_restart", 32'(restart), 0);
    key_start = 1'b0;

    // first hit: two consecutive overlapping ticks
    barrel_on();
    do_tick(); chk("hit1_t1_lives", 32'(lives), 3);
    do_tick(); chk("hit1_lives", 32'(lives), 2);
    chk("hit1_invuln", 32'(invuln), 1);
    for (int i = 0; i < 59; i++) do_tick();
    chk("inv59_invuln", 32'(invuln), 1);
    chk("inv59_lives", 32'(lives), 2);
    do_tick();
    chk("inv60_invuln", 32'(invuln), 0);
    chk("inv60_lives", 32'(lives), 2);

    // touching edge is not an overlap, and it breaks a hit streak
    barrel_x = 10'd134;
    do_tick(); do_tick(); do_tick();
    chk("touch_lives", 32'(lives), 2);
    barrel_on(); do_tick();
    barrel_x = 10'd134; do_tick();
    barrel_on(); do_tick();
    chk("touch_break_lives", 32'(lives), 2);
    for (int i = 0; i < 3; i++) begin
      barrel_off(); do_tick();
      barrel_on(); do_tick();
    end
    chk("alt_lives", 32'(lives), 2);
    chk("alt_invuln", 32'(invuln), 0);

    // second hit (streak continues from the last overlapping tick), then let window expire
    do_tick();
    chk("hit2_lives", 32'(lives), 1);
    chk("hit2_invuln", 32'(invuln), 1);
    barrel_off();
    for (int i = 0; i < 60; i++) do_tick();
    chk("hit2_expired", 32'(invuln), 0);

    // third hit -> game over
    barrel_on();
    do_tick(); chk("hit3_t1_over", 32'(over), 0);
    do_tick();
    chk("hit3_lives", 32'(lives), 0);
    chk("hit3_over", 32'(over), 1);
    chk("hit3_invuln", 32'(invuln), 0);
    do_tick(); do_tick(); do_tick();
    chk("over_hold_lives", 32'(lives), 0);
    chk("over_hold", 32'(over), 1);

    game_state = 2'b10;
    key_start = 1'b1; step();
    chk("restart_pulse", 32'(restart), 1);
    chk("restart_no_start", 32'(start), 0);
    key_start = 1'b0; step();
    chk("restart_one_clk", 32'(restart), 0);

    game_state = 2'b00; step();
    chk("init_over", 32'(over), 0);
    chk("init_lives", 32'(lives), 3);
    chk("init_invuln", 32'(invuln), 0);

    // goal beats a simultaneous barrel hit
    game_state = 2'b01;
    mario_x = 10'd290; mario_y = 9'd50;
    barrel_x = 10'd300; barrel_y = 9'd60;
    do_tick();
    chk("goal_pre_lives", 32'(lives), 3);
    queue_x = 10'd300; queue_y = 9'd60;
    do_tick();
    chk("goal_success", 32'(success), 1);
    chk("goal_lives", 32'(lives), 3);
    chk("goal_over", 32'(over), 0);
    do_tick(); do_tick();
    chk("goal_hold_lives", 32'(lives), 3);
    chk("goal_hold_over", 32'(over), 0);
    game_state = 2'b11;
    key_start = 1'b1; step();
    chk("succ_restart", 32'(restart), 1);
    key_start = 1'b0;

    // reset mid-invulnerability
    game_state = 2'b00; step();
    chk("init2_success", 32'(success), 0);
    game_state = 2'b01;
    mario_x = 10'd100; mario_y = 9'd200;
    queue_x = 10'd900; queue_y = 9'd400;
    barrel_on();
    do_tick(); do_tick();
    chk("pre_rst_invuln", 32'(invuln), 1);
    rst = 1'b1; step();
    chk("mid_rst_invuln", 32'(invuln), 0);
    chk("mid_rst_lives", 32'(lives), 3);
    rst = 1'b0;

    // Queue box corner clamps to 0 near the screen origin
    game_state = 2'b00; step();
    game_state = 2'b01;
    barrel_off();
    mario_x = 10'd30; mario_y = 9'd30;
    queue_x = 10'd10; queue_y = 9'd20;
    do_tick();
    chk("clamp_goal", 32'(success), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
